// File: rtl/context_stack_seq.sv
// -----------------------------------------------------------------------------
// context_stack_seq
//
// Memory-stage sequencer that saves a processor context (PC segments and,
// optionally, flags) to a downward-growing stack and restores it later.
// The PC is serialised into DATA_W-wide words, one per cycle. While the
// sequence runs the pipeline is stalled. When idle, the normal ALU/memory
// request passes straight through to data memory.
//
// Stack discipline:
//   push : write at SP, then SP <= SP - 1   (post-decrement)
//   pop  : read at SP + 1, SP <= SP + 1     (pre-increment)
// Push word order is PC high segment .. PC low segment, then flags when
// mode = 1. Pop reads the words back in the exact reverse order.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start_push/start_pop  begin save/restore; sampled only in IDLE, push wins
//   mode                  0 = PC only, 1 = PC + flags; latched at start
//   pc_in, flags_in       context to save; latched at start
//   alu_in, addr_in,
//   we_in, re_in          pass-through memory request used in IDLE
//   mem_rdata             memory read data, valid one cycle after mem_re
//   mem_we, mem_re,
//   mem_addr, mem_wdata   data memory request
//   busy                  pipeline stall request
//   pc_out, flags_out     restored context, held until the next restore
//   restore_valid         one-cycle pulse while pc_out/flags_out are new
//   sp_out                current stack pointer
//   sp_wrap               one-cycle pulse after SP wraps past 0 or all-ones
// -----------------------------------------------------------------------------
module context_stack_seq #(
    parameter int DATA_W  = 16,
    parameter int PC_SEGS = 2,
    parameter int FLAG_W  = 3,
    parameter int SP_W    = 12,
    parameter logic [SP_W-1:0] SP_RESET = {SP_W{1'b1}}
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_push,
    input  logic                      start_pop,
    input  logic                      mode,
    input  logic [DATA_W*PC_SEGS-1:0] pc_in,
    input  logic [FLAG_W-1:0]         flags_in,
    input  logic [DATA_W-1:0]         alu_in,
    input  logic [SP_W-1:0]           addr_in,
    input  logic                      we_in,
    input  logic                      re_in,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      mem_we,
    output logic                      mem_re,
    output logic [SP_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      busy,
    output logic [DATA_W*PC_SEGS-1:0] pc_out,
    output logic [FLAG_W-1:0]         flags_out,
    output logic                      restore_valid,
    output logic [SP_W-1:0]           sp_out,
    output logic                      sp_wrap
);

    localparam int PC_W  = DATA_W * PC_SEGS;
    // Counter must hold 0..PC_SEGS (K-1 with flags) plus headroom for cnt-1.
    localparam int CNT_W = $clog2(PC_SEGS + 2);

    typedef enum logic [1:0] {
        IDLE,
        PUSH,
        POP,
        DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic                mode_q, mode_d;
    logic [PC_W-1:0]     pc_q, pc_d;           // PC being pushed
    logic [FLAG_W-1:0]   flags_q, flags_d;     // flags being pushed
    logic [PC_W-1:0]     pc_sh_q, pc_sh_d;     // partial restore shadow
    logic [FLAG_W-1:0]   flags_sh_q, flags_sh_d;
    logic [PC_W-1:0]     pc_out_q, pc_out_d;
    logic [FLAG_W-1:0]   flags_out_q, flags_out_d;
    logic                restore_valid_q, restore_valid_d;
    logic                sp_wrap_q, sp_wrap_d;

    // Index of the last word of the current sequence (K-1).
    logic [CNT_W-1:0]    k_last;
    assign k_last = CNT_W'(PC_SEGS - 1) + CNT_W'(mode_q);

    // -------------------------------------------------------------------------
    // Push data selection: word i is PC segment PC_SEGS-1-i, the extra word
    // (mode = 1) is the zero-extended flags.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] push_word;
    logic [CNT_W-1:0]  push_seg;

    always_comb begin
        // NOTE: every signal written in always_comb gets a default first so no
        // path through the block leaves it unassigned and infers a latch.
        push_word = '0;
        push_seg  = CNT_W'(PC_SEGS - 1) - cnt_q;
        if (mode_q && (cnt_q == CNT_W'(PC_SEGS))) begin
            push_word = DATA_W'(flags_q);
        end else begin
            for (int s = 0; s < PC_SEGS; s++) begin
                if (push_seg == CNT_W'(s)) begin
                    push_word = pc_q[s*DATA_W +: DATA_W];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pop capture: read data returns one cycle after its read, so in POP cycle
    // i (i > 0) the data belongs to read i-1, and in DRAIN to read K-1.
    // Read j maps to flags when mode = 1 and j = 0, otherwise to PC segment
    // j - mode (low segment first).
    // -------------------------------------------------------------------------
    logic              cap_pend;
    logic [CNT_W-1:0]  cap_idx;
    logic [CNT_W-1:0]  cap_seg;
    logic [PC_W-1:0]   pc_cap;
    logic [FLAG_W-1:0] flags_cap;

    always_comb begin
        cap_pend  = ((state_q == POP) && (cnt_q != '0)) || (state_q == DRAIN);
        cap_idx   = (state_q == DRAIN) ? k_last : (cnt_q - CNT_W'(1));
        cap_seg   = cap_idx - CNT_W'(mode_q);
        pc_cap    = pc_sh_q;
        flags_cap = flags_sh_q;
        if (cap_pend) begin
            if (mode_q && (cap_idx == '0)) begin
                flags_cap = mem_rdata[FLAG_W-1:0];
            end else begin
                for (int s = 0; s < PC_SEGS; s++) begin
                    if (cap_seg == CNT_W'(s)) begin
                        pc_cap[s*DATA_W +: DATA_W] = mem_rdata;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state, stack pointer and memory request.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        sp_d            = sp_q;
        mode_d          = mode_q;
        pc_d            = pc_q;
        flags_d         = flags_q;
        pc_sh_d         = pc_sh_q;
        flags_sh_d      = flags_sh_q;
        pc_out_d        = pc_out_q;
        flags_out_d     = flags_out_q;
        restore_valid_d = 1'b0;
        sp_wrap_d       = 1'b0;

        mem_we    = we_in;
        mem_re    = re_in;
        mem_addr  = addr_in;
        mem_wdata = alu_in;

        unique case (state_q)
            IDLE: begin
                if (start_push) begin
                    state_d = PUSH;
                    cnt_d   = '0;
                    mode_d  = mode;
                    pc_d    = pc_in;
                    flags_d = flags_in;
                end else if (start_pop) begin
                    state_d = POP;
                    cnt_d   = '0;
                    mode_d  = mode;
                end
            end

            PUSH: begin
                mem_we    = 1'b1;
                mem_re    = 1'b0;
                mem_addr  = sp_q;
                mem_wdata = push_word;
                sp_d      = sp_q - SP_W'(1);
                sp_wrap_d = (sp_q == '0);
                if (cnt_q == k_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            POP: begin
                mem_we     = 1'b0;
                mem_re     = 1'b1;
                mem_addr   = sp_q + SP_W'(1);
                mem_wdata  = '0;
                sp_d       = sp_q + SP_W'(1);
                sp_wrap_d  = (sp_q == '1);
                pc_sh_d    = pc_cap;
                flags_sh_d = flags_cap;
                if (cnt_q == k_last) begin
                    state_d         = DRAIN;
                    cnt_d           = '0;
                    restore_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DRAIN: begin
                mem_we    = 1'b0;
                mem_re    = 1'b0;
                mem_addr  = sp_q;
                mem_wdata = '0;
                state_d   = IDLE;
                pc_out_d  = pc_cap;
                // A PC-only restore leaves the previously restored flags alone.
                if (mode_q) begin
                    flags_out_d = flags_cap;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers. Reset aborts any sequence at once: back to IDLE, SP
    // reloaded, partial restore data discarded.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: all state here is a handful of flops, so every register is
            // reset; nothing is a memory array that would need to stay unreset.
            state_q         <= IDLE;
            cnt_q           <= '0;
            sp_q            <= SP_RESET;
            mode_q          <= 1'b0;
            pc_q            <= '0;
            flags_q         <= '0;
            pc_sh_q         <= '0;
            flags_sh_q      <= '0;
            pc_out_q        <= '0;
            flags_out_q     <= '0;
            restore_valid_q <= 1'b0;
            sp_wrap_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            sp_q            <= sp_d;
            mode_q          <= mode_d;
            pc_q            <= pc_d;
            flags_q         <= flags_d;
            pc_sh_q         <= pc_sh_d;
            flags_sh_q      <= flags_sh_d;
            pc_out_q        <= pc_out_d;
            flags_out_q     <= flags_out_d;
            restore_valid_q <= restore_valid_d;
            sp_wrap_q       <= sp_wrap_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. The final pop word only arrives during DRAIN, so the restored
    // context is forwarded combinationally in that cycle and held afterwards.
    // -------------------------------------------------------------------------
    assign busy          = (state_q != IDLE);
    assign pc_out        = (state_q == DRAIN) ? pc_cap : pc_out_q;
    assign flags_out     = ((state_q == DRAIN) && mode_q) ? flags_cap : flags_out_q;
    assign restore_valid = restore_valid_q;
    assign sp_out        = sp_q;
    assign sp_wrap       = sp_wrap_q;

endmodule

// File: tb/tb_context_stack_seq.sv
// -----------------------------------------------------------------------------
// tb_context_stack_seq
//
// Directed bench for context_stack_seq with DATA_W=16, PC_SEGS=2, FLAG_W=3,
// SP_W=12. A small synchronous memory model answers reads one cycle after
// mem_re. Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_context_stack_seq;

    logic        clk;
    logic        rst_n;
    logic        start_push;
    logic        start_pop;
    logic        mode;
    logic [31:0] pc_in;
    logic [2:0]  flags_in;
    logic [15:0] alu_in;
    logic [11:0] addr_in;
    logic        we_in;
    logic        re_in;
    logic [15:0] mem_rdata;
    logic        mem_we;
    logic        mem_re;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic [31:0] pc_out;
    logic [2:0]  flags_out;
    logic        restore_valid;
    logic [11:0] sp_out;
    logic        sp_wrap;

    int checks = 0;
    int errors = 0;
    int wrap_cnt = 0;
    int w0;

    context_stack_seq #(
        .DATA_W  (16),
        .PC_SEGS (2),
        .FLAG_W  (3),
        .SP_W    (12)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_push    (start_push),
        .start_pop     (start_pop),
        .mode          (mode),
        .pc_in         (pc_in),
        .flags_in      (flags_in),
        .alu_in        (alu_in),
        .addr_in       (addr_in),
        .we_in         (we_in),
        .re_in         (re_in),
        .mem_rdata     (mem_rdata),
        .mem_we        (mem_we),
        .mem_re        (mem_re),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .busy          (busy),
        .pc_out        (pc_out),
        .flags_out     (flags_out),
        .restore_valid (restore_valid),
        .sp_out        (sp_out),
        .sp_wrap       (sp_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous data memory: read data appears one cycle after mem_re.
    logic [15:0] mem [0:4095];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // Count sp_wrap pulses (one count per high cycle).
    always @(posedge clk) begin
        if (sp_wrap) wrap_cnt <= wrap_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start_push = 1'b0;
        start_pop  = 1'b0;
        mode       = 1'b0;
        pc_in      = '0;
        flags_in   = '0;
        alu_in     = '0;
        addr_in    = '0;
        we_in      = 1'b0;
        re_in      = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_sp", sp_out, 32'hFFF);
        check("rst_busy", busy, 0);
        check("rst_pc_out", pc_out, 0);
        check("rst_flags_out", flags_out, 0);
        check("rst_restore_valid", restore_valid, 0);
        check("rst_sp_wrap", sp_wrap, 0);
        we_in   = 1'b1;
        addr_in = 12'h010;
        alu_in  = 16'hBEEF;
        #1;
        check("rst_pass_we", mem_we, 1);
        check("rst_pass_addr", mem_addr, 32'h010);
        check("rst_pass_wdata", mem_wdata, 32'hBEEF);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- idle pass-through ----------------
        @(negedge clk);
        check("idle_we", mem_we, 1);
        check("idle_addr", mem_addr, 32'h010);
        check("idle_wdata", mem_wdata, 32'hBEEF);
        check("idle_busy", busy, 0);
        we_in = 1'b0;
        re_in = 1'b1;
        #1;
        check("idle_re", mem_re, 1);
        check("idle_we_off", mem_we, 0);
        re_in = 1'b0;

        // ---------------- push mode=1 from reset ----------------
        w0         = wrap_cnt;
        start_push = 1'b1;
        mode       = 1'b1;
        pc_in      = 32'h1234_5678;
        flags_in   = 3'b101;
        @(negedge clk);
        start_push = 1'b0;
        mode       = 1'b0;
        pc_in      = '0;
        flags_in   = '0;
        check("push1_we", mem_we, 1);
        check("push1_re", mem_re, 0);
        check("push1_addr", mem_addr, 32'hFFF);
        check("push1_data", mem_wdata, 32'h1234);
        check("push1_busy", busy, 1);
        @(negedge clk);
        check("push2_addr", mem_addr, 32'hFFE);
        check("push2_data", mem_wdata, 32'h5678);
        check("push2_busy", busy, 1);
        @(negedge clk);
        check("push3_addr", mem_addr, 32'hFFD);
        check("push3_data", mem_wdata, 32'h0005);
        check("push3_busy", busy, 1);
        @(negedge clk);
        check("push_done_busy", busy, 0);
        check("push_done_sp", sp_out, 32'hFFC);
        check("push_done_we", mem_we, 0);
        check("push_no_wrap", wrap_cnt - w0, 0);

        // ---------------- pop mode=1 ----------------
        start_pop = 1'b1;
        mode      = 1'b1;
        @(negedge clk);
        start_pop = 1'b0;
        mode      = 1'b0;
        check("pop1_re", mem_re, 1);
        check("pop1_we", mem_we, 0);
        check("pop1_addr", mem_addr, 32'hFFD);
        check("pop1_busy", busy, 1);
        @(negedge clk);
        check("pop2_addr", mem_addr, 32'hFFE);
        check("pop2_valid", restore_valid, 0);
        @(negedge clk);
        check("pop3_addr", mem_addr, 32'hFFF);
        check("pop3_valid", restore_valid, 0);
        @(negedge clk);
        check("drain_valid", restore_valid, 1);
        check("drain_pc", pc_out, 32'h1234_5678);
        check("drain_flags", flags_out, 32'h5);
        check("drain_sp", sp_out, 32'hFFF);
        check("drain_busy", busy, 1);
        check("drain_re", mem_re, 0);
        @(negedge clk);
        check("pop_done_busy", busy, 0);
        check("pop_done_valid", restore_valid, 0);
        check("pop_hold_pc", pc_out, 32'h1234_5678);
        check("pop_hold_flags", flags_out, 32'h5);

        // ---------------- reset mid-push ----------------
        start_push = 1'b1;
        mode       = 1'b1;
        pc_in      = 32'hCAFE_BABE;
        flags_in   = 3'b011;
        @(negedge clk);
        start_push = 1'b0;
        check("rpush1_addr", mem_addr, 32'hFFF);
        check("rpush1_data", mem_wdata, 32'hCAFE);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rpush_abort_busy", busy, 0);
        check("rpush_abort_sp", sp_out, 32'hFFF);
        check("rpush_abort_we", mem_we, 0);
        check("rpush_abort_pc_out", pc_out, 0);
        @(negedge clk);
        check("rpush_hold_we", mem_we, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rpush_after_we", mem_we, 0);
        check("rpush_after_busy", busy, 0);
        check("rpush_after_sp", sp_out, 32'hFFF);

        // Pop from SP=0xFFF reads from 0x000 upward after wrapping.
        w0        = wrap_cnt;
        start_pop = 1'b1;
        mode      = 1'b1;
        @(negedge clk);
        start_pop = 1'b0;
        check("rpop1_addr", mem_addr, 32'h000);
        check("rpop1_re", mem_re, 1);
        @(negedge clk);
        check("rpop2_addr", mem_addr, 32'h001);
        @(negedge clk);
        check("rpop3_addr", mem_addr, 32'h002);
        @(negedge clk);
        check("rpop_drain_valid", restore_valid, 1);
        @(negedge clk);
        check("rpop_sp", sp_out, 32'h002);
        check("rpop_wrap_once", wrap_cnt - w0, 1);

        // Bring SP to 0x000 with a PC-only push (writes 0x002, 0x001).
        start_push = 1'b1;
        mode       = 1'b0;
        pc_in      = 32'h0000_0000;
        @(negedge clk);
        start_push = 1'b0;
        repeat (2) @(negedge clk);
        check("prep_sp", sp_out, 32'h000);

        // ---------------- wrap: push mode=0 from SP=0x000 ----------------
        w0         = wrap_cnt;
        start_push = 1'b1;
        mode       = 1'b0;
        pc_in      = 32'hAAAA_5555;
        @(negedge clk);
        start_push = 1'b0;
        check("wpush1_addr", mem_addr, 32'h000);
        check("wpush1_data", mem_wdata, 32'hAAAA);
        @(negedge clk);
        check("wpush2_addr", mem_addr, 32'hFFF);
        check("wpush2_data", mem_wdata, 32'h5555);
        @(negedge clk);
        check("wpush_busy", busy, 0);
        check("wpush_sp", sp_out, 32'hFFE);
        check("wpush_wrap_once", wrap_cnt - w0, 1);

        // Matching pop restores SP=0x000 with one wrap pulse.
        w0        = wrap_cnt;
        start_pop = 1'b1;
        mode      = 1'b0;
        @(negedge clk);
        start_pop = 1'b0;
        check("wpop1_addr", mem_addr, 32'hFFF);
        @(negedge clk);
        check("wpop2_addr", mem_addr, 32'h000);
        @(negedge clk);
        check("wpop_drain_valid", restore_valid, 1);
        check("wpop_pc", pc_out, 32'hAAAA_5555);
        check("wpop_sp", sp_out, 32'h000);
        @(negedge clk);
        check("wpop_busy", busy, 0);
        check("wpop_wrap_once", wrap_cnt - w0, 1);

        // ---------------- arbitration ----------------
        start_push = 1'b1;
        start_pop  = 1'b1;
        mode       = 1'b0;
        pc_in      = 32'h0F0F_F0F0;
        @(negedge clk);
        start_push = 1'b0;
        start_pop  = 1'b0;
        check("arb1_we", mem_we, 1);
        check("arb1_re", mem_re, 0);
        check("arb1_addr", mem_addr, 32'h000);
        check("arb1_data", mem_wdata, 32'h0F0F);
        @(negedge clk);
        start_pop = 1'b1;
        #1;
        check("arb2_we", mem_we, 1);
        check("arb2_re", mem_re, 0);
        check("arb2_addr", mem_addr, 32'hFFF);
        check("arb2_data", mem_wdata, 32'hF0F0);
        @(negedge clk);
        start_pop = 1'b0;
        check("arb3_busy", busy, 0);
        check("arb3_re", mem_re, 0);
        check("arb3_sp", sp_out, 32'hFFE);
        @(negedge clk);
        check("arb4_busy", busy, 0);
        check("arb4_re", mem_re, 0);
        check("arb4_sp", sp_out, 32'hFFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
